tdm_demux16: RTL and testbench
==============================

// Module: tdm_demux16
// PURPOSE
// - Receive end of the 16-channel TDM link: the transmit side walks mux16's 4-bit select and sends one bit per slot.
// - Re-aligns to frame sync, steers each serial bit to its channel position and presents a complete 16-bit frame on a
//   valid/ready output with a one-frame holding register.
// - Sits between the serial link pins and the channel-consumer logic.
// PARAMETERS
// - NCH            16  channels (slots) per frame; power of two
// - SEL_W          4   slot counter width, $clog2(NCH)
// - SYNC_LOSS_MAX  2   consecutive missing fsyncs at slot 0 before lock is dropped
// PORTS
// - clk        in   1      rising-edge clock; one clock domain
// - rst        in   1      synchronous reset, active-high
// - sin        in   1      serial data bit for the current slot
// - sin_valid  in   1      sin/fsync are sampled only when 1
// - fsync      in   1      marks the beat carrying slot 0
// - out        out  NCH    frame word; out[i] = slot-i bit
// - out_valid  out  1      out holds an unconsumed frame
// - out_ready  in   1      consumer accepts out on the clk edge where out_valid=1
// - ch_sel     out  SEL_W  slot index the next accepted beat is written to (mirror of tx select)
// - locked     out  1      1 = frame alignment held
// - sync_err   out  1      1-cycle pulse: fsync seen at slot != 0 while locked
// - overrun    out  1      1-cycle pulse: completed frame dropped because buffer full
// BEHAVIOUR
// - Reset: state=HUNT, slot=0, out=0, out_valid=0, ch_sel=0, locked=0, sync_err=0, overrun=0, miss_cnt=0, shadow=0.
//   Reset mid-frame discards the partial frame and any held frame.
// - Beats with sin_valid=0 change nothing; gaps of any length are legal.
// - HUNT: beats with fsync=0 are ignored. Beat with fsync=1: shadow[0]<=sin, slot<=1, state<=LOCKED, locked<=1.
// - LOCKED, each beat: shadow[slot]<=sin; slot<=slot+1, wrapping NCH-1 -> 0.
// - LOCKED, beat at slot 0 with fsync=0: miss_cnt++.
//   - If the new value == SYNC_LOSS_MAX: beat discarded, state<=HUNT, locked<=0, slot<=0, miss_cnt<=0.
//   - Otherwise the beat is accepted (flywheel).
// - LOCKED, beat at slot 0 with fsync=1: miss_cnt<=0.
// - LOCKED, beat at slot != 0 with fsync=1: sync_err pulse next cycle; partial frame discarded;
//   the beat becomes slot 0 (shadow[0]<=sin, slot<=1); miss_cnt<=0; stays LOCKED.
// - Frame completes on the accepted beat at slot NCH-1.
//   - If out_valid=0, or out_valid&out_ready on the same edge: out<={sin, shadow[NCH-2:0]}, out_valid=1 next cycle.
//   - Latency: out_valid rises one clk after the last beat.
//   - Else the new frame is dropped, out is unchanged, and overrun pulses next cycle.
// - out_valid&out_ready with no frame completing: out_valid<=0 and out holds its value.
// - out never changes while out_valid=1 && out_ready=0.
// - ch_sel = registered slot. sync_err and overrun are registered, never high more than 1 cycle per event.
// STRUCTURE
// - Package tdm_pkg: NCH, SEL_W, SYNC_LOSS_MAX defaults; typedef enum logic {HUNT, LOCKED} tdm_state_t;
//   typedef logic [NCH-1:0] tdm_frame_t.
// - Sub-module tdm_slot_ctr: slot counter with load-1/clear/wrap and miss_cnt; FSM, shadow and output buffer stay top-level.
// - No combinational path from sin/fsync/out_ready to any output.
// TESTING
// - Lock and basic frame: rst 2 cycles; send 16'hAAAA slot0-first, fsync on slot 0, out_ready=1
//   -> locked=1 after beat 0; out=16'hAAAA, out_valid=1 one clk after beat 15, then cleared.
// - Backpressure: out_ready=0; send 16'h1234 then 16'hFFFF -> out stays 16'h1234, overrun pulses once after frame 2;
//   out_ready=1 -> out_valid falls.
// - Misalignment: locked; fsync at slot 5 -> sync_err 1 cycle, ch_sel=1 next; next 16 beats yield that frame intact.
// - Sync loss: locked; omit fsync at 2 consecutive slot-0 beats -> first frame still delivered, second slot-0 beat
//   drops lock (locked=0, ch_sel=0); re-lock on next fsync.
// - Gaps and wrap: sin_valid toggled 1-0-0-1 over frame 16'h8001 -> out=16'h8001; ch_sel wraps 15 -> 0.
// - Reset mid-frame: rst asserted at slot 9 and while out_valid=1 -> all outputs 0 next cycle, HUNT, prior frame not emitted.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and sizing for the 16-channel TDM receive path.
// Frame width, slot counter width and sync-loss threshold.
package tdm_pkg;
  localparam int NCH           = 16;
  localparam int SEL_W         = $clog2(NCH);
  localparam int SYNC_LOSS_MAX = 2;
  localparam int MISS_W        = $clog2(SYNC_LOSS_MAX + 1);

  typedef enum logic {HUNT, LOCKED} tdm_state_t;
  typedef logic [NCH-1:0] tdm_frame_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter and missing-fsync flywheel counter.
// Slot wraps naturally because NCH is a power of two.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             load1,
  input  logic             clear,
  input  logic             miss_inc,
  input  logic             miss_clr,
  output logic [SEL_W-1:0] slot,
  output logic             miss_hit
);

  logic [SEL_W-1:0]  slot_d, slot_q;
  logic [MISS_W-1:0] miss_d, miss_q;
  logic [MISS_W-1:0] miss_nxt;

  // Next slot and miss count; clear wins over load, load over advance
  always_comb begin
    slot_d   = slot_q;
    miss_d   = miss_q;
    miss_nxt = miss_q + 1'b1;
    if (clear)      slot_d = '0;
    else if (load1) slot_d = SEL_W'(1);
    else if (adv)   slot_d = slot_q + 1'b1;
    if (clear || miss_clr) miss_d = '0;
    else if (miss_inc)     miss_d = miss_nxt;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      miss_q <= '0;
    end else begin
      slot_q <= slot_d;
      miss_q <= miss_d;
    end
  end

  assign slot     = slot_q;
  assign miss_hit = (miss_nxt == MISS_W'(SYNC_LOSS_MAX));

endmodule

// File: rtl/tdm_demux16.sv
// TDM receive demux: aligns to fsync, assembles 16-bit frames,
// and holds one completed frame on a valid/ready output.
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             fsync,
  output logic [NCH-1:0]   out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] ch_sel,
  output logic             locked,
  output logic             sync_err,
  output logic             overrun
);

  tdm_state_t       state_d, state_q;
  tdm_frame_t       shadow_d, shadow_q;
  tdm_frame_t       out_d, out_q;
  logic             ov_d, ov_q;
  logic             se_d, se_q;
  logic             orun_d, orun_q;

  logic             adv, load1, clear;
  logic             miss_inc, miss_clr, miss_hit;
  logic [SEL_W-1:0] slot;
  logic             slot_zero;
  logic             accept, done;

  tdm_slot_ctr u_ctr (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .load1    (load1),
    .clear    (clear),
    .miss_inc (miss_inc),
    .miss_clr (miss_clr),
    .slot     (slot),
    .miss_hit (miss_hit)
  );

  assign slot_zero = (slot == '0);

  // Alignment FSM, shadow assembly and output hand-off
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    ov_d     = ov_q;
    se_d     = 1'b0;
    orun_d   = 1'b0;
    adv      = 1'b0;
    load1    = 1'b0;
    clear    = 1'b0;
    miss_inc = 1'b0;
    miss_clr = 1'b0;
    accept   = 1'b0;
    done     = 1'b0;
    if (sin_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            shadow_d[0] = sin;
            load1       = 1'b1;
            miss_clr    = 1'b1;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync && !slot_zero) begin
            se_d        = 1'b1;
            shadow_d[0] = sin;
            load1       = 1'b1;
            miss_clr    = 1'b1;
          end else if (slot_zero && !fsync && miss_hit) begin
            state_d = HUNT;
            clear   = 1'b1;
          end else begin
            accept = 1'b1;
            if (slot_zero) begin
              miss_clr = fsync;
              miss_inc = !fsync;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (accept) begin
      shadow_d[slot] = sin;
      adv            = 1'b1;
      done           = (slot == SEL_W'(NCH - 1));
    end
    if (done) begin
      if (!ov_q || out_ready) begin
        out_d = shadow_d;
        ov_d  = 1'b1;
      end else begin
        orun_d = 1'b1;
      end
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  // State, frame and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      out_q    <= '0;
      ov_q     <= 1'b0;
      se_q     <= 1'b0;
      orun_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ov_q     <= ov_d;
      se_q     <= se_d;
      orun_q   <= orun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign ch_sel    = slot;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = se_q;
  assign overrun   = orun_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Bench for tdm_demux16: directed scenarios plus random traffic
// compared every cycle against a behavioural receiver model.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        fsync = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dout;
  logic        out_valid;
  logic [3:0]  ch_sel;
  logic        locked;
  logic        sync_err;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;

  bit        m_lock;
  int        m_slot;
  int        m_miss;
  bit [15:0] m_sh;
  bit [15:0] m_out;
  bit        m_ov;
  bit        m_se;
  bit        m_orun;

  tdm_demux16 dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .fsync     (fsync),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_sel    (ch_sel),
    .locked    (locked),
    .sync_err  (sync_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Receiver behaviour: one step per clock edge
  task automatic model_step();
    bit done;
    bit drop;
    done = 0;
    if (rst) begin
      m_lock = 0; m_slot = 0; m_miss = 0; m_sh = '0;
      m_out = '0; m_ov = 0; m_se = 0; m_orun = 0;
      return;
    end
    m_se = 0;
    m_orun = 0;
    if (sin_valid) begin
      if (!m_lock) begin
        if (fsync) begin
          m_sh[0] = sin; m_slot = 1; m_lock = 1; m_miss = 0;
        end
      end else if (fsync && m_slot != 0) begin
        m_se = 1; m_sh[0] = sin; m_slot = 1; m_miss = 0;
      end else begin
        drop = 0;
        if (m_slot == 0) begin
          if (fsync) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == 2) begin
              drop = 1; m_lock = 0; m_slot = 0; m_miss = 0;
            end
          end
        end
        if (!drop) begin
          m_sh[m_slot] = sin;
          done = (m_slot == 15);
          m_slot = (m_slot + 1) % 16;
        end
      end
    end
    if (done) begin
      if (!m_ov || out_ready) begin
        m_out = m_sh; m_ov = 1;
      end else m_orun = 1;
    end else if (m_ov && out_ready) m_ov = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("out", dout, m_out);
    chk("out_valid", out_valid, m_ov);
    chk("ch_sel", ch_sel, m_slot);
    chk("locked", locked, m_lock);
    chk("sync_err", sync_err, m_se);
    chk("overrun", overrun, m_orun);
  endtask

  task automatic beat(input bit b, input bit fs);
    sin = b; fsync = fs; sin_valid = 1;
    cyc();
    sin_valid = 0; fsync = 0;
  endtask

  task automatic idle();
    sin_valid = 0;
    cyc();
  endtask

  task automatic frame(input logic [15:0] w, input bit fs0);
    for (int i = 0; i < 16; i++) beat(w[i], fs0 && i == 0);
  endtask

  initial begin
    logic [15:0] w;
    int tx;
    rst = 1;
    cyc();
    cyc();
    chk("rst_out", dout, 16'h0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_lock", locked, 1'b0);
    chk("rst_sel", ch_sel, 4'd0);
    rst = 0;

    // lock and basic frame
    out_ready = 1;
    w = 16'hAAAA;
    beat(w[0], 1);
    chk("lock_b0", locked, 1'b1);
    for (int i = 1; i < 16; i++) beat(w[i], 0);
    chk("aaaa_out", dout, 16'hAAAA);
    chk("aaaa_ov", out_valid, 1'b1);
    idle();
    chk("aaaa_clr", out_valid, 1'b0);

    // backpressure
    out_ready = 0;
    frame(16'h1234, 1);
    chk("bp_out1", dout, 16'h1234);
    frame(16'hFFFF, 1);
    chk("bp_orun", overrun, 1'b1);
    chk("bp_hold", dout, 16'h1234);
    idle();
    chk("bp_orun1", overrun, 1'b0);
    out_ready = 1;
    idle();
    chk("bp_drain", out_valid, 1'b0);

    // misalignment: fsync arrives at slot 5
    for (int i = 0; i < 5; i++) beat(1'b1, i == 0);
    w = 16'h5A3C;
    beat(w[0], 1);
    chk("mis_err", sync_err, 1'b1);
    chk("mis_sel", ch_sel, 4'd1);
    beat(w[1], 0);
    chk("mis_err1", sync_err, 1'b0);
    for (int i = 2; i < 16; i++) beat(w[i], 0);
    chk("mis_out", dout, 16'h5A3C);

    // sync loss: two missing slot-0 fsyncs
    frame(16'hC3E1, 0);
    chk("loss_fly", dout, 16'hC3E1);
    chk("loss_flyv", out_valid, 1'b1);
    beat(1'b1, 0);
    chk("loss_lock", locked, 1'b0);
    chk("loss_sel", ch_sel, 4'd0);
    frame(16'h0F0F, 1);
    chk("relock_out", dout, 16'h0F0F);
    chk("relock_lk", locked, 1'b1);

    // gaps and wrap
    w = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("gap_sel15", ch_sel, 4'd15);
      beat(w[i], i == 0);
      if (i < 15 && i % 2 == 0) begin
        idle();
        idle();
      end
    end
    chk("gap_wrap", ch_sel, 4'd0);
    chk("gap_out", dout, 16'h8001);

    // reset mid-frame with a held frame
    out_ready = 0;
    frame(16'h1111, 1);
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
    chk("mid_sel9", ch_sel, 4'd9);
    rst = 1;
    beat(1'b1, 0);
    rst = 0;
    chk("mid_out", dout, 16'h0);
    chk("mid_ov", out_valid, 1'b0);
    chk("mid_lock", locked, 1'b0);
    chk("mid_sel", ch_sel, 4'd0);
    for (int i = 10; i < 16; i++) beat(1'b1, 0);
    idle();
    chk("mid_nofrm", out_valid, 1'b0);

    // random traffic
    tx = 0;
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 599) == 0);
      sin_valid = ($urandom_range(0, 9) < 7);
      sin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (tx == 0) fsync = ($urandom_range(0, 19) != 0);
      else         fsync = ($urandom_range(0, 59) == 0);
      if (sin_valid) tx = (tx + 1) % 16;
      cyc();
    end
    rst = 0;
    sin_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
